servo_pwm_multi: RTL and testbench
==================================

// Module: servo_pwm_multi
// PURPOSE
//   Multi-channel servo PWM generator. Avalon-MM slave in Computer_System; generalises servo_basic to NUM_CH channels.
//   Adds programmable frame period, per-channel target pulse width and slew-rate limiting.
//   Register updates are glitch-free: they take effect only at frame boundaries.
//   pwm_out[k] is exported to Arduino/GPIO header pins at the top level.
// PARAMETERS
//   NUM_CH        4         number of PWM channels (1..12)
//   CLK_HZ        50000000  clk frequency
//   TICK_HZ       1000000   PWM time base; DIV = CLK_HZ/TICK_HZ clk cycles per tick (DIV >= 2)
//   W             16        width of period/width/slew fields, in ticks
//   DEF_PERIOD    20000     reset frame period, in ticks
//   DEF_WIDTH     1500      reset pulse width for every channel, in ticks
//   MIN_WIDTH     500       lower clamp for target width
//   MAX_WIDTH     2500      upper clamp for target width (< DEF_PERIOD)
// PORTS
//   clk            in   1       system clock
//   reset          in   1       synchronous, active-high
//   avs_address    in   4       word address
//   avs_read       in   1       read strobe
//   avs_write      in   1       write strobe
//   avs_writedata  in   32      write data
//   avs_readdata   out  32      read data, valid 1 cycle after avs_read
//   pwm_out        out  NUM_CH  servo pulse outputs
//   frame_sync     out  1       1-cycle pulse at each frame start
// BEHAVIOUR
//   Register map (word address). Only the low W bits of data are used unless stated.
//     0 CTRL:   [NUM_CH-1:0] channel enables, R/W.
//     1 PERIOD: R/W. Written value below MAX_WIDTH+1 is stored as MAX_WIDTH+1.
//     2 SLEW:   R/W. Ticks of width change per frame; 0 = jump straight to target.
//     3 STATUS: RO. Bit k = 1 when cur[k] == tgt[k].
//     4+k TARGET[k]: R/W. Clamped to [MIN_WIDTH, MAX_WIDTH] on write.
//   Unmapped address: write ignored, read returns 0. No wait states.
//   Read data is registered (fixed read latency 1). Read-during-write returns the old value.
//   Reset: pwm_out=0, frame_sync=0, readdata=0, CTRL=0, PERIOD=DEF_PERIOD, SLEW=0.
//     Also on reset: tgt=cur=DEF_WIDTH, prescaler=0, frame_cnt=0, all active shadows loaded from the reset values.
//   Reset mid-frame: outputs go low on the next edge; a new frame starts from 0.
//   Prescaler counts 0..DIV-1. tick is asserted on the cycle it holds DIV-1; it then wraps to 0.
//   frame_cnt increments on tick over 0..per_act-1.
//   frame_start = tick && frame_cnt == per_act-1.
//   On frame_start, all of these happen in the same cycle:
//     - frame_cnt <= 0
//     - per_act <= PERIOD
//     - en_act <= CTRL
//     - frame_sync <= 1 (next cycle only)
//     - per channel, with s = SLEW:
//         s==0: cur <= tgt
//         cur<tgt: cur <= min(cur+s, tgt)
//         cur>tgt: cur <= max(cur-s, tgt)
//     Arithmetic is W+1 bits wide, so there is no wrap.
//   pwm_out[k] (registered) = en_act[k] && (frame_cnt < cur[k]).
//     A disabled channel is held at 0 for the whole frame.
//     A channel enabled mid-frame starts at the next frame.
//   Register write in the same cycle as frame_start: the frame update uses the old value; the new value applies next frame.
//   PERIOD change mid-frame: the current frame completes with the old per_act.
// TESTING
//   (Bench params: CLK_HZ=4, TICK_HZ=1, so DIV=4; DEF_PERIOD=20, MIN=2, MAX=10, DEF_WIDTH=5.)
//   1. Reset, then write CTRL=1 -> from the next frame, pwm_out[0] high 20 clk, low 60 clk; frame_sync every 80 clk.
//   2. TARGET[0]=100 -> reads back 10. TARGET[0]=0 -> reads back 2. Read of address 15 -> 0.
//   3. SLEW=2, TARGET[0]=10 from cur=5 -> widths 7, 9, 10 on successive frames; STATUS[0]=1 after the third frame.
//   4. PERIOD=30 written mid-frame -> current frame stays 20 ticks, next frame is 30 ticks. PERIOD=3 -> reads back 11.
//   5. Write TARGET[1] in the frame_start cycle -> new width appears one frame later. CTRL toggled mid-frame -> no runt pulse.
//   6. Assert reset while pwm_out=1 -> all outputs 0 on the next edge; registers return to reset values.

Source files
------------

// File: rtl/servo_pwm_multi_if.sv
// Avalon-MM slave bus bundle for servo_pwm_multi.
// The master drives address/strobes/write data; the slave returns registered read data.
interface servo_pwm_multi_if;
    logic [3:0]  avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic [31:0] avs_readdata;

    modport master (
        output avs_address,
        output avs_read,
        output avs_write,
        output avs_writedata,
        input  avs_readdata
    );

    modport slave (
        input  avs_address,
        input  avs_read,
        input  avs_write,
        input  avs_writedata,
        output avs_readdata
    );
endinterface

// File: rtl/servo_pwm_multi.sv
// Multi-channel servo PWM generator behind an Avalon-MM slave.
// A prescaler derives a tick from clk; a frame counter runs over the active period.
// Period, enables and per-channel widths are shadowed and only move at frame boundaries,
// so a pulse in flight is never cut short or stretched by a register write.
module servo_pwm_multi #(
    parameter int NUM_CH     = 4,
    parameter int CLK_HZ     = 50000000,
    parameter int TICK_HZ    = 1000000,
    parameter int W          = 16,
    parameter int DEF_PERIOD = 20000,
    parameter int DEF_WIDTH  = 1500,
    parameter int MIN_WIDTH  = 500,
    parameter int MAX_WIDTH  = 2500
) (
    input  logic               clk,
    input  logic               reset,
    servo_pwm_multi_if.slave   bus,
    output logic [NUM_CH-1:0]  pwm_out,
    output logic               frame_sync
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [PW-1:0] DIV_M1  = PW'(DIV - 1);
    localparam logic [W-1:0]  MIN_W   = W'(MIN_WIDTH);
    localparam logic [W-1:0]  MAX_W   = W'(MAX_WIDTH);
    localparam logic [W-1:0]  MIN_PER = W'(MAX_WIDTH + 1);
    localparam logic [W-1:0]  DEF_PER = W'(DEF_PERIOD);
    localparam logic [W-1:0]  DEF_W   = W'(DEF_WIDTH);

    // Programmed (bus-visible) registers
    logic [NUM_CH-1:0] r_ctrl;
    logic [W-1:0]      r_period;
    logic [W-1:0]      r_slew;
    logic [W-1:0]      r_tgt [NUM_CH];

    // Active state used by the running frame
    logic [PW-1:0]     r_presc;
    logic [W-1:0]      r_frame_cnt;
    logic [W-1:0]      r_per_act;
    logic [NUM_CH-1:0] r_en_act;
    logic [W-1:0]      r_cur [NUM_CH];
    logic [31:0]       r_readdata;

    logic              w_tick;
    logic              w_frame_start;
    logic [W-1:0]      w_wdata;
    logic [W-1:0]      w_tgt_clamped;
    logic [W-1:0]      w_per_clamped;
    logic [NUM_CH-1:0] w_status;
    logic [W-1:0]      w_cur_next [NUM_CH];
    logic [W:0]        w_up       [NUM_CH];
    logic [W:0]        w_floor    [NUM_CH];
    logic [31:0]       w_rd_mux;

    assign w_tick        = (r_presc == DIV_M1);
    assign w_frame_start = w_tick && (r_frame_cnt == r_per_act - 1'b1);

    assign w_wdata       = bus.avs_writedata[W-1:0];
    assign w_tgt_clamped = (w_wdata < MIN_W) ? MIN_W :
                           (w_wdata > MAX_W) ? MAX_W : w_wdata;
    assign w_per_clamped = (w_wdata < MIN_PER) ? MIN_PER : w_wdata;

    assign bus.avs_readdata = r_readdata;

    // Slew-limited next width per channel, computed one bit wider so the step never wraps
    always_comb begin
        for (int k = 0; k < NUM_CH; k++) begin
            w_up[k]       = {1'b0, r_cur[k]} + {1'b0, r_slew};
            w_floor[k]    = {1'b0, r_tgt[k]} + {1'b0, r_slew};
            w_status[k]   = (r_cur[k] == r_tgt[k]);
            w_cur_next[k] = r_cur[k];
            if (r_slew == '0) begin
                w_cur_next[k] = r_tgt[k];
            end else if (r_cur[k] < r_tgt[k]) begin
                w_cur_next[k] = (w_up[k] >= {1'b0, r_tgt[k]}) ? r_tgt[k] : w_up[k][W-1:0];
            end else if (r_cur[k] > r_tgt[k]) begin
                w_cur_next[k] = ({1'b0, r_cur[k]} <= w_floor[k]) ? r_tgt[k] : r_cur[k] - r_slew;
            end
        end
    end

    // Read-data mux over the register map; unmapped addresses read as zero
    always_comb begin
        // NOTE: the default comes first so every path assigns w_rd_mux and no latch is inferred.
        w_rd_mux = '0;
        case (bus.avs_address)
            4'd0: w_rd_mux[NUM_CH-1:0] = r_ctrl;
            4'd1: w_rd_mux[W-1:0]      = r_period;
            4'd2: w_rd_mux[W-1:0]      = r_slew;
            4'd3: w_rd_mux[NUM_CH-1:0] = w_status;
            default: begin
                for (int k = 0; k < NUM_CH; k++) begin
                    if (bus.avs_address == 4'(4 + k)) begin
                        w_rd_mux[W-1:0] = r_tgt[k];
                    end
                end
            end
        endcase
    end

    // Bus-writable registers; values are clamped on the way in
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ctrl   <= '0;
            r_period <= DEF_PER;
            r_slew   <= '0;
            // NOTE: these arrays are small flop banks, not RAM, so they are given reset values.
            for (int k = 0; k < NUM_CH; k++) begin
                r_tgt[k] <= DEF_W;
            end
        end else if (bus.avs_write) begin
            case (bus.avs_address)
                4'd0: r_ctrl   <= bus.avs_writedata[NUM_CH-1:0];
                4'd1: r_period <= w_per_clamped;
                4'd2: r_slew   <= w_wdata;
                4'd3: ;
                default: begin
                    for (int k = 0; k < NUM_CH; k++) begin
                        if (bus.avs_address == 4'(4 + k)) begin
                            r_tgt[k] <= w_tgt_clamped;
                        end
                    end
                end
            endcase
        end
    end

    // Time base, frame counter and frame-boundary loading of the active shadows
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: non-blocking updates mean every register here samples pre-edge values,
            // which is what makes a same-cycle bus write land one frame later.
            r_presc     <= '0;
            r_frame_cnt <= '0;
            r_per_act   <= DEF_PER;
            r_en_act    <= '0;
            frame_sync  <= 1'b0;
            for (int k = 0; k < NUM_CH; k++) begin
                r_cur[k] <= DEF_W;
            end
        end else begin
            r_presc    <= w_tick ? '0 : r_presc + 1'b1;
            frame_sync <= w_frame_start;
            if (w_frame_start) begin
                r_frame_cnt <= '0;
                r_per_act   <= r_period;
                r_en_act    <= r_ctrl;
                for (int k = 0; k < NUM_CH; k++) begin
                    r_cur[k] <= w_cur_next[k];
                end
            end else if (w_tick) begin
                r_frame_cnt <= r_frame_cnt + 1'b1;
            end
        end
    end

    // Registered read data, fixed latency of one cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_readdata <= '0;
        end else if (bus.avs_read) begin
            r_readdata <= w_rd_mux;
        end
    end

    // Registered pulse outputs; disabled channels stay low for the whole frame
    always_ff @(posedge clk) begin
        if (reset) begin
            pwm_out <= '0;
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                pwm_out[k] <= r_en_act[k] && (r_frame_cnt < r_cur[k]);
            end
        end
    end

endmodule

// File: tb/tb_servo_pwm_multi.sv
// Self-checking bench for servo_pwm_multi with DIV=4, period 20 ticks (80 clk), widths 2..10.
// Expected read values and per-frame pulse measurements are queued when stimulus is issued
// and popped when the DUT result is sampled.
module tb_servo_pwm_multi;

    localparam int NUM_CH = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [NUM_CH-1:0] pwm_out;
    logic              frame_sync;

    int                n_total = 0;
    int                n_bad   = 0;
    logic [31:0]       q_exp [$];

    servo_pwm_multi_if bus ();

    servo_pwm_multi #(
        .NUM_CH     (NUM_CH),
        .CLK_HZ     (4),
        .TICK_HZ    (1),
        .W          (16),
        .DEF_PERIOD (20),
        .DEF_WIDTH  (5),
        .MIN_WIDTH  (2),
        .MAX_WIDTH  (10)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus.slave),
        .pwm_out    (pwm_out),
        .frame_sync (frame_sync)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Drive a write in the current (low) phase; it is captured on the next rising edge
    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        bus.avs_address   = a;
        bus.avs_writedata = d;
        bus.avs_write     = 1'b1;
        @(negedge clk);
        bus.avs_write     = 1'b0;
    endtask

    task automatic bus_read(input string tag, input logic [3:0] a, input logic [31:0] exp);
        bus.avs_address = a;
        bus.avs_read    = 1'b1;
        q_exp.push_back(exp);
        @(posedge clk);
        @(negedge clk);
        bus.avs_read    = 1'b0;
        check(tag, bus.avs_readdata, q_exp.pop_front());
    endtask

    // Count cycles (and high cycles of one channel) from now until frame_sync is seen
    task automatic count_to_fs(input int ch, output int n, output int h);
        n = 0;
        h = 0;
        while (!frame_sync && n < 1000) begin
            h += int'(pwm_out[ch]);
            n++;
            @(negedge clk);
        end
        if (!frame_sync) check("fs_timeout", 32'(frame_sync), 32'd1);
    endtask

    // Measure one whole frame starting at the next (or current) frame_sync
    task automatic measure(input string tag, input int ch, input int exp_h, input int exp_len);
        int w;
        int n;
        int h;
        int h0;
        w = 0;
        while (!frame_sync && w < 1000) begin
            @(negedge clk);
            w++;
        end
        if (!frame_sync) begin
            check({tag, "_wait"}, 32'(frame_sync), 32'd1);
            return;
        end
        q_exp.push_back(32'(exp_h));
        q_exp.push_back(32'(exp_len));
        h0 = int'(pwm_out[ch]);
        @(negedge clk);
        count_to_fs(ch, n, h);
        check({tag, "_high"}, 32'(h + h0), q_exp.pop_front());
        check({tag, "_len"},  32'(n + 1),  q_exp.pop_front());
    endtask

    initial begin
        int n;
        int h;
        bus.avs_address   = '0;
        bus.avs_read      = 1'b0;
        bus.avs_write     = 1'b0;
        bus.avs_writedata = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_pwm",  32'(pwm_out),    32'd0);
        check("rst_fs",   32'(frame_sync), 32'd0);
        check("rst_rd",   bus.avs_readdata, 32'd0);
        reset = 1'b0;
        bus_read("rst_ctrl",   4'd0, 32'd0);
        bus_read("rst_period", 4'd1, 32'd20);
        bus_read("rst_slew",   4'd2, 32'd0);
        bus_read("rst_tgt0",   4'd4, 32'd5);
        bus_read("rst_status", 4'd3, 32'hF);

        // 1: enable channel 0, width 5 ticks = 20 clk in an 80 clk frame
        bus_write(4'd0, 32'd1);
        measure("t1_f1", 0, 20, 80);
        measure("t1_f2", 0, 20, 80);

        // 2: target clamping and unmapped read
        bus_write(4'd4, 32'd100);
        bus_read("t2_clamp_hi", 4'd4, 32'd10);
        bus_write(4'd4, 32'd0);
        bus_read("t2_clamp_lo", 4'd4, 32'd2);
        bus_read("t2_unmapped", 4'd15, 32'd0);
        bus_write(4'd4, 32'd5);
        measure("t2_restore", 0, 20, 80);

        // 3: slew 2 from 5 to 10 -> 7, 9, 10
        bus_write(4'd2, 32'd2);
        bus_write(4'd4, 32'd10);
        bus_read("t3_status_pre", 4'd3, 32'hE);
        measure("t3_w7",  0, 28, 80);
        measure("t3_w9",  0, 36, 80);
        measure("t3_w10", 0, 40, 80);
        bus_read("t3_status_post", 4'd3, 32'hF);

        // 4: PERIOD change mid-frame keeps the current frame at 20 ticks
        measure("t4_pre", 0, 40, 80);
        bus_write(4'd1, 32'd30);
        count_to_fs(0, n, h);
        check("t4_cur_len",  32'(n), 32'd79);
        check("t4_cur_high", 32'(h), 32'd40);
        measure("t4_p30", 0, 40, 120);
        bus_write(4'd1, 32'd3);
        bus_read("t4_per_clamp", 4'd1, 32'd11);
        bus_write(4'd1, 32'd20);
        bus_write(4'd2, 32'd0);
        bus_write(4'd0, 32'd3);

        // 5: TARGET[1] written in the frame_start cycle applies one frame later
        measure("t5_ch1_base", 1, 20, 80);
        repeat (79) @(negedge clk);
        bus_write(4'd5, 32'd8);
        measure("t5_ch1_old", 1, 20, 80);
        measure("t5_ch1_new", 1, 32, 80);
        // Toggle CTRL off/on mid-frame: the running pulse is not cut
        bus_write(4'd0, 32'd2);
        bus_write(4'd0, 32'd3);
        count_to_fs(0, n, h);
        check("t5_toggle_len",  32'(n), 32'd78);
        check("t5_toggle_high", 32'(h), 32'd39);
        // Disable mid-frame: rest of frame unchanged, next frame silent
        bus_write(4'd0, 32'd2);
        count_to_fs(0, n, h);
        check("t5_dis_cur_high", 32'(h), 32'd40);
        measure("t5_dis_next", 0, 0, 80);

        // 6: reset while a pulse is high
        @(negedge clk);
        @(negedge clk);
        check("t6_pulse_high", 32'(pwm_out), 32'h2);
        reset = 1'b1;
        @(negedge clk);
        check("t6_rst_pwm", 32'(pwm_out),    32'd0);
        check("t6_rst_fs",  32'(frame_sync), 32'd0);
        check("t6_rst_rd",  bus.avs_readdata, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        bus_read("t6_ctrl",   4'd0, 32'd0);
        bus_read("t6_period", 4'd1, 32'd20);
        bus_read("t6_slew",   4'd2, 32'd0);
        bus_read("t6_tgt0",   4'd4, 32'd5);
        bus_read("t6_tgt1",   4'd5, 32'd5);
        bus_read("t6_status", 4'd3, 32'hF);
        bus_write(4'd0, 32'd1);
        measure("t6_after", 0, 20, 80);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
